// File: rtl/mips_pkg.sv
// Shared MIPS control-path constants: main-decoder opcodes, loader command kinds
// and encoder FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] KIND_LW    = 3'd0;
  localparam logic [2:0] KIND_SW    = 3'd1;
  localparam logic [2:0] KIND_RTYPE = 3'd2;
  localparam logic [2:0] KIND_ADDI  = 3'd3;
  localparam logic [2:0] KIND_BEQ   = 3'd4;
  localparam logic [2:0] KIND_J     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: command kind plus fields -> 32-bit MIPS word.
// legal is low for kinds 6 and 7, in which case word is zero.
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      KIND_LW:    word = {OP_LW,    rs, rt, imm};
      KIND_SW:    word = {OP_SW,    rs, rt, imm};
      KIND_ADDI:  word = {OP_ADDI,  rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ,   rs, rt, imm};
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_J:     word = {OP_J,     target};
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams packed MIPS instructions into instruction memory at sequential word
// addresses, one word per accepted command, with a one-cycle write latency.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [5:0]        cmd_funct,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_kind
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W:0]   ptr_reg;
  logic              err_reg;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;

  logic [31:0]       pack_word;
  logic              pack_legal;
  logic              accept;

  mips_instr_pack u_pack (
    .kind   (cmd_kind),
    .rs     (cmd_rs),
    .rt     (cmd_rt),
    .rd     (cmd_rd),
    .funct  (cmd_funct),
    .imm    (cmd_imm),
    .target (cmd_target),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign cmd_ready = (state_reg == ST_LOAD);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= BASE_ADDR;
      wdata_reg <= '0;
    end else begin
      we_reg <= 1'b0;
      if (load_start) begin
        // Restart wins over load_end and over any command offered this cycle.
        state_reg <= ST_LOAD;
        ptr_reg   <= '0;
        err_reg   <= 1'b0;
      end else begin
        if (accept) begin
          if (pack_legal) begin
            we_reg    <= 1'b1;
            addr_reg  <= BASE_ADDR + {{(29 - ADDR_W){1'b0}}, ptr_reg, 2'b00};
            wdata_reg <= pack_word;
            ptr_reg   <= ptr_reg + 1'b1;
            if (ptr_reg == LAST_V) state_reg <= ST_FULL;
          end else begin
            err_reg <= 1'b1;
          end
        end
        if (load_end) state_reg <= ST_IDLE;
      end
    end
  end

  // The pointer doubles as the word count: both reset and advance together.
  assign count      = ptr_reg;
  assign full       = (ptr_reg == DEPTH_V);
  assign err_kind   = err_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: encoding table, directed corner
// sequences and a randomized run against a behavioural loader model.
module tb_mips_instr_encoder;

  localparam int          ADDR_W = 2;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_end, cmd_valid, cmd_ready;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [5:0]  cmd_funct;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [ADDR_W:0] count;
  logic        full, err_kind;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_funct(cmd_funct),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .full(full), .err_kind(err_kind)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a loader session is either open or closed, holding a number of words.
  bit          m_open;
  int          m_words;
  bit          m_err;
  bit          m_we;
  int          m_kind;
  logic [31:0] m_addr, m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int k, input int rs, input int rt, input int rd,
                                           input int fn, input int imm, input int tg);
    longint unsigned opc [6] = '{35, 43, 0, 8, 4, 2};
    longint unsigned w;
    if (k == 2)
      w = opc[k] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
    else if (k == 5)
      w = opc[k] * 64'd67108864 + tg;
    else
      w = opc[k] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    return w[31:0];
  endfunction

  // Instruction class as the main decoder sees it, from the opcode alone.
  function automatic int dec_class(input logic [31:0] w);
    case (int'(w[31:26]))
      35: return 0;
      43: return 1;
      0:  return 2;
      8:  return 3;
      4:  return 4;
      2:  return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_open = 0; m_words = 0; m_err = 0; m_we = 0; m_kind = -1;
    m_addr = BASE; m_data = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(m_open && m_words < DEPTH));
    chk({tag, ".we"},    32'(imem_we),   32'(m_we));
    chk({tag, ".addr"},  imem_addr, m_addr);
    chk({tag, ".wdata"}, imem_wdata, m_data);
    chk({tag, ".count"}, 32'(count), 32'(m_words));
    chk({tag, ".full"},  32'(full),  32'(m_words == DEPTH));
    chk({tag, ".err"},   32'(err_kind), 32'(m_err));
    if (imem_we === 1'b1 && m_we)
      chk({tag, ".class"}, 32'(dec_class(imem_wdata)), 32'(m_kind));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input string tag, input bit ls, input bit le, input bit v,
                       input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg);
    bit ready;
    load_start = ls; load_end = le; cmd_valid = v; cmd_kind = k;
    cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_funct = fn; cmd_imm = imm; cmd_target = tg;
    ready = m_open && m_words < DEPTH;
    m_we = 0;
    if (ls) begin
      m_open = 1; m_words = 0; m_err = 0;
    end else begin
      if (v && ready) begin
        if (int'(k) <= 5) begin
          m_we = 1;
          m_kind = int'(k);
          m_addr = BASE + 32'(4 * m_words);
          m_data = ref_word(int'(k), int'(rs), int'(rt), int'(rd), int'(fn), int'(imm), int'(tg));
          m_words++;
        end else begin
          m_err = 1;
        end
      end
      if (le) m_open = 0;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  task automatic start(input string tag);
    cycle(tag, 1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  typedef struct {
    logic [2:0]  k;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{3'd0, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h8C22_0004};
    tbl[1] = '{3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0008, 26'h0, 32'hAC22_0008};
    tbl[2] = '{3'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 32'h0022_1820};
    tbl[3] = '{3'd3, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010, 26'h0, 32'h2064_0010};
    tbl[4] = '{3'd4, 5'd4, 5'd5, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h1085_FFFF};
    tbl[5] = '{3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 32'h0800_0010};

    rst = 1; load_start = 0; load_end = 0; cmd_valid = 0; cmd_kind = 0;
    cmd_rs = 0; cmd_rt = 0; cmd_rd = 0; cmd_funct = 0; cmd_imm = 0; cmd_target = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(posedge clk); #1;
    rst = 0;
    idle("post_reset");

    // Encoding table: each word written alone at the base address.
    for (int i = 0; i < 6; i++) begin
      start("tbl_start");
      cycle("tbl_cmd", 0, 0, 1, tbl[i].k, tbl[i].rs, tbl[i].rt, tbl[i].rd,
            tbl[i].fn, tbl[i].imm, tbl[i].tg);
      chk("tbl_word", imem_wdata, tbl[i].exp);
      chk("tbl_addr", imem_addr, BASE);
    end

    // Back-to-back SW, RTYPE, J: continuous strobe, addresses stepping by 4.
    start("b2b_start");
    cycle("b2b_sw", 0, 0, 1, 3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0008, 26'h0);
    cycle("b2b_rt", 0, 0, 1, 3'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0);
    chk("b2b_addr1", imem_addr, BASE + 32'd4);
    cycle("b2b_j",  0, 0, 1, 3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10);
    chk("b2b_addr2", imem_addr, BASE + 32'd8);
    chk("b2b_data2", imem_wdata, 32'h0800_0010);
    idle("b2b_idle");

    // Fill all four words, then a fifth valid is refused; restart goes to base.
    start("fill_start");
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 0, 0, 1, 3'd3, 5'(i), 5'd7, 5'd0, 6'h00, 16'(i * 3), 26'h0);
    chk("fill_last_addr", imem_addr, BASE + 32'd12);
    chk("fill_full", 32'(full), 32'd1);
    cycle("fill_5th", 0, 0, 1, 3'd0, 5'd9, 5'd9, 5'd0, 6'h00, 16'h1234, 26'h0);
    start("fill_restart");
    cycle("fill_again", 0, 0, 1, 3'd0, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0001, 26'h0);
    chk("fill_again_addr", imem_addr, BASE);

    // Illegal kind consumed without a write, then BEQ lands at base.
    start("ill_start");
    cycle("ill_k7", 0, 0, 1, 3'd7, 5'd4, 5'd5, 5'd0, 6'h00, 16'hFFFF, 26'h0);
    cycle("ill_beq", 0, 0, 1, 3'd4, 5'd4, 5'd5, 5'd0, 6'h00, 16'hFFFF, 26'h0);
    chk("ill_beq_data", imem_wdata, 32'h1085_FFFF);

    // Accept together with load_end, then load_start together with load_end.
    start("end_start");
    cycle("end_acc", 0, 1, 1, 3'd0, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0040, 26'h0);
    cycle("both", 1, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0);

    // Asynchronous reset while a write strobe is high.
    cycle("rst_acc", 0, 0, 1, 3'd1, 5'd6, 5'd7, 5'd0, 6'h00, 16'h0020, 26'h0);
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    cycle("rst_after", 0, 0, 1, 3'd0, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0001, 26'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit ls, le, v;
      ls = ($urandom_range(0, 19) == 0);
      le = ($urandom_range(0, 24) == 0);
      v  = !ls && ($urandom_range(0, 2) != 0);
      cycle("rand", ls, le, v, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
            5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
